axi4_lite_terminator: RTL and testbench
=======================================

Name: axi4_lite_terminator

Overview:
Parametrised AXI4-Lite slave endpoint for otherwise unused or unmapped address windows. It completes every transaction so a master can never hang. Writes are discarded; reads return a fixed fill pattern; every response carries a configurable BRESP/RRESP. It counts accesses and captures the last offending addresses, which lets software diagnose stray accesses to dead regions.

Parameters:
DW, 32, data width in bits (multiple of 8)
AW, 32, address width in bits
RESP, 2'b11, response code driven on BRESP and RRESP (2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR)
FILL, 32'hDEAD_BEEF, read data value; zero-extended or truncated to DW
CW, 16, width of the access counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  AW  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DW  write data (ignored)
S_AXI_WSTRB  in  DW/8  write strobes (ignored)
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  AW  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
clear  in  1  synchronous clear of counters and captured addresses
wr_count  out  CW  completed write transactions, saturating
rd_count  out  CW  completed read transactions, saturating
last_wr_addr  out  AW  AWADDR of the most recent AW handshake
last_rd_addr  out  AW  ARADDR of the most recent AR handshake
access  out  1  one-cycle pulse per accepted address

Behaviour:
- Reset (async assert; takes effect on the next clk edge after release):
  - All outputs 0, including all READY and VALID signals, counters and addresses.
  - In the first clk edge after release, AWREADY, WREADY and ARREADY go 1.
  - Reset mid-transaction drops any pending B or R response.
- All outputs are registered; no combinational path from input to output.
- Write channel, one transaction outstanding:
  - AW and W are accepted independently, in either order or in the same cycle.
  - After an AW handshake, AWREADY is 0 from the next cycle. Likewise WREADY after a W handshake.
  - Once both are captured (cycle N = the later handshake), BVALID=1 and BRESP=RESP in N+1.
  - BVALID holds until BREADY. On the B handshake in cycle M, AWREADY and WREADY return to 1 in M+1.
- Read channel, one transaction outstanding:
  - AR handshake in cycle N gives ARREADY=0, RVALID=1, RDATA=FILL, RRESP=RESP in N+1.
  - RVALID, RDATA and RRESP are stable until RREADY. On the R handshake in cycle M, ARREADY=1 in M+1.
  - RDATA is 0 whenever RVALID=0.
- Read and write channels are fully independent and may be active simultaneously.
- Throughput: at most 1 read and 1 write per 2 cycles.
- wr_count:
  - +1 on each B handshake.
  - Saturates at 2^CW-1 (no wrap).
- rd_count:
  - +1 on each R handshake.
  - Saturates at 2^CW-1 (no wrap).
- last_wr_addr and last_rd_addr load on their address handshakes.
- access:
  - 1 in the cycle after any AW or AR handshake.
  - AW and AR handshakes in the same cycle give a single pulse.
- clear:
  - Zeroes wr_count, rd_count, last_wr_addr and last_rd_addr next cycle.
  - Clear wins over a simultaneous increment or address capture.
  - Does not affect handshake state.

Test Plan:
- Reset release, all VALIDs low -> all READYs 1 one cycle after release; all outputs 0 during reset.
- AW=0x1000 at cycle 5, W at cycle 8, BREADY=1 -> BVALID in cycle 9 with BRESP=2'b11; wr_count=1; last_wr_addr=0x1000; access pulse in cycle 6; AWREADY and WREADY 1 again in cycle 10.
- AR=0x2004 with RREADY held 0 for 4 cycles -> RVALID/RDATA=0xDEADBEEF/RRESP=2'b11 stable throughout; ARREADY=0 until the cycle after RREADY=1; rd_count=1.
- Simultaneous AW+W+AR in the same cycle -> BVALID and RVALID both rise next cycle; exactly one access pulse.
- CW=4 and 20 back-to-back reads -> rd_count sticks at 15; clear asserted in the same cycle as an R handshake -> rd_count=0.
- Assert reset while BVALID=1 -> BVALID drops immediately and wr_count=0; a new write after release completes normally.

Source files
------------

// File: rtl/axi4_lite_terminator.sv
// AXI4-Lite sink for unmapped address windows: completes every access with a
// fixed response, discards writes, returns a fill pattern and logs stray hits.
module axi4_lite_terminator #(
    parameter int          DW   = 32,
    parameter int          AW   = 32,
    parameter logic [1:0]  RESP = 2'b11,
    parameter logic [31:0] FILL = 32'hDEAD_BEEF,
    parameter int          CW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   S_AXI_AWADDR,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [DW-1:0]   S_AXI_WDATA,
    input  logic [DW/8-1:0] S_AXI_WSTRB,
    input  logic            S_AXI_WVALID,
    output logic            S_AXI_WREADY,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [AW-1:0]   S_AXI_ARADDR,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    output logic [DW-1:0]   S_AXI_RDATA,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY,
    input  logic            clear,
    output logic [CW-1:0]   wr_count,
    output logic [CW-1:0]   rd_count,
    output logic [AW-1:0]   last_wr_addr,
    output logic [AW-1:0]   last_rd_addr,
    output logic            access
);
    localparam logic [DW-1:0] FILL_DW = DW'(FILL);

    logic          unused_wdata;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d, arready_q, arready_d;
    logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] wr_count_q, wr_count_d, rd_count_q, rd_count_d;
    logic [AW-1:0] last_wr_q, last_wr_d, last_rd_q, last_rd_d;
    logic          access_q, access_d;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_have, w_have, start_b;

    assign unused_wdata = ^{S_AXI_WDATA, S_AXI_WSTRB};

    always_comb begin
        aw_hs   = S_AXI_AWVALID & awready_q;
        w_hs    = S_AXI_WVALID & wready_q;
        b_hs    = bvalid_q & S_AXI_BREADY;
        ar_hs   = S_AXI_ARVALID & arready_q;
        r_hs    = rvalid_q & S_AXI_RREADY;
        aw_have = aw_done_q | aw_hs;
        w_have  = w_done_q | w_hs;
        start_b = aw_have & w_have & ~bvalid_q;

        // Captured halves are consumed once the response is launched; the
        // READYs then stay low on the strength of BVALID alone.
        bvalid_d  = start_b | (bvalid_q & ~S_AXI_BREADY);
        aw_done_d = aw_have & ~start_b;
        w_done_d  = w_have & ~start_b;
        awready_d = ~aw_done_d & ~bvalid_d;
        wready_d  = ~w_done_d & ~bvalid_d;
        bresp_d   = bvalid_d ? RESP : 2'b00;

        rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
        arready_d = ~rvalid_d;
        rdata_d   = rvalid_d ? FILL_DW : '0;
        rresp_d   = rvalid_d ? RESP : 2'b00;

        access_d   = aw_hs | ar_hs;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        last_wr_d  = last_wr_q;
        last_rd_d  = last_rd_q;
        if (clear) begin
            wr_count_d = '0;
            rd_count_d = '0;
            last_wr_d  = '0;
            last_rd_d  = '0;
        end else begin
            if (b_hs && !(&wr_count_q)) wr_count_d = wr_count_q + CW'(1);
            if (r_hs && !(&rd_count_q)) rd_count_d = rd_count_q + CW'(1);
            if (aw_hs) last_wr_d = S_AXI_AWADDR;
            if (ar_hs) last_rd_d = S_AXI_ARADDR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            last_wr_q  <= '0;
            last_rd_q  <= '0;
            access_q   <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            last_wr_q  <= last_wr_d;
            last_rd_q  <= last_rd_d;
            access_q   <= access_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign last_wr_addr  = last_wr_q;
    assign last_rd_addr  = last_rd_q;
    assign access        = access_q;
endmodule

// File: tb/tb_axi4_lite_terminator.sv
// Self-checking bench for axi4_lite_terminator: vector table with a response
// scoreboard plus hand-written multi-cycle sequences.
module tb_axi4_lite_terminator;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;
    localparam logic [1:0] XRESP = 2'b11;
    localparam logic [31:0] XFILL = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, clear = 0;
    logic [DW-1:0] wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, access;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;
    logic [CW-1:0] wr_count, rd_count;
    logic [AW-1:0] last_wr_addr, last_rd_addr;

    always #5 clk = ~clk;

    axi4_lite_terminator #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .clear(clear),
        .wr_count(wr_count), .rd_count(rd_count), .last_wr_addr(last_wr_addr),
        .last_rd_addr(last_rd_addr), .access(access)
    );

    typedef struct {
        bit          wr;
        bit          w_first;
        logic [31:0] addr;
        int          hold;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[6];
    int errs = 0;
    int checks = 0;
    int mwr = 0;
    int mrd = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (!awready && n < 20) begin tick; n++; end
        if (!awready) timeout("aw_ready");
        tick;
        awvalid = 1'b0;
        chk("aw_access", access, 1);
        chk("aw_last_addr", last_wr_addr, a);
    endtask

    task automatic send_w;
        int n = 0;
        wdata = $urandom;
        wstrb = 4'hF;
        wvalid = 1'b1;
        while (!wready && n < 20) begin tick; n++; end
        if (!wready) timeout("w_ready");
        tick;
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin tick; n++; end
        if (!arready) timeout("ar_ready");
        tick;
        arvalid = 1'b0;
        chk("ar_access", access, 1);
    endtask

    task automatic wait_b(input int hold);
        int n = 0;
        exp_t e;
        while (!bvalid && n < 20) begin tick; n++; end
        if (!bvalid) begin timeout("b_valid"); return; end
        repeat (hold) begin
            tick;
            chk("b_hold", bvalid, 1);
        end
        e = sbq.pop_front();
        chk("bresp", bresp, e.resp);
        chk("last_wr_addr", last_wr_addr, e.addr);
        bready = 1'b1;
        tick;
        bready = 1'b0;
        mwr = sat(mwr + 1);
        chk("wr_count", wr_count, mwr);
        chk("awready_back", awready, 1);
        chk("wready_back", wready, 1);
    endtask

    task automatic wait_r(input int hold);
        int n = 0;
        exp_t e;
        while (!rvalid && n < 20) begin tick; n++; end
        if (!rvalid) begin timeout("r_valid"); return; end
        repeat (hold) begin
            tick;
            chk("r_hold", rvalid, 1);
        end
        e = sbq.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        chk("last_rd_addr", last_rd_addr, e.addr);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        mrd = sat(mrd + 1);
        chk("rd_count", rd_count, mrd);
        chk("arready_back", arready, 1);
        chk("rdata_idle", rdata, 0);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wr) begin
            if (v.w_first) begin send_w(); send_aw(v.addr); end
            else begin send_aw(v.addr); send_w(); end
            sbq.push_back('{v.resp, 32'h0, v.addr});
            wait_b(v.hold);
        end else begin
            send_ar(v.addr);
            sbq.push_back('{v.resp, v.data, v.addr});
            wait_r(v.hold);
        end
    endtask

    initial begin
        int hs;
        int n;
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 0, XRESP, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 3, XRESP, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0300, 0, XRESP, XFILL};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 2, XRESP, XFILL};
        vecs[4] = '{1'b1, 1'b0, 32'hABCD_0000, 1, XRESP, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 5, XRESP, XFILL};

        tick;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_counts", {wr_count, rd_count}, 0);
        chk("rst_addrs", {last_wr_addr, last_rd_addr}, 0);
        chk("rst_access", access, 0);
        reset = 1'b0;
        tick;
        chk("rel_readys", {awready, wready, arready}, 3'b111);

        // AW first, W three cycles later, BREADY already high
        awaddr = 32'h1000;
        awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        chk("hw_access", access, 1);
        chk("hw_awready_lo", awready, 0);
        chk("hw_last_wr", last_wr_addr, 32'h1000);
        tick;
        chk("hw_access_pulse", access, 0);
        chk("hw_awready_held", awready, 0);
        chk("hw_bvalid_early", bvalid, 0);
        tick;
        wvalid = 1'b1;
        bready = 1'b1;
        tick;
        wvalid = 1'b0;
        chk("hw_bvalid", bvalid, 1);
        chk("hw_bresp", bresp, XRESP);
        chk("hw_wready_lo", wready, 0);
        tick;
        bready = 1'b0;
        mwr = sat(mwr + 1);
        chk("hw_bvalid_done", bvalid, 0);
        chk("hw_readys_back", {awready, wready}, 2'b11);
        chk("hw_wr_count", wr_count, mwr);

        // read held off by RREADY=0 for four cycles
        araddr = 32'h2004;
        arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rh_rvalid", rvalid, 1);
            chk("rh_rdata", rdata, XFILL);
            chk("rh_rresp", rresp, XRESP);
            chk("rh_arready", arready, 0);
            tick;
        end
        chk("rh_last_rd", last_rd_addr, 32'h2004);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        mrd = sat(mrd + 1);
        chk("rh_arready_back", arready, 1);
        chk("rh_rdata_idle", rdata, 0);
        chk("rh_rd_count", rd_count, mrd);

        foreach (vecs[i]) run_vec(vecs[i]);
        chk("sb_empty", sbq.size(), 0);

        // AW, W and AR together: one access pulse, both responses next cycle
        awaddr = 32'h4000;
        araddr = 32'h5000;
        {awvalid, wvalid, arvalid} = 3'b111;
        tick;
        {awvalid, wvalid, arvalid} = 3'b000;
        chk("sim_valids", {bvalid, rvalid}, 2'b11);
        chk("sim_access", access, 1);
        tick;
        chk("sim_access_once", access, 0);
        {bready, rready} = 2'b11;
        tick;
        {bready, rready} = 2'b00;
        mwr = sat(mwr + 1);
        mrd = sat(mrd + 1);
        chk("sim_counts", {wr_count, rd_count}, {mwr[CW-1:0], mrd[CW-1:0]});

        // clear beats an address capture but not the handshake
        araddr = 32'h6000;
        arvalid = 1'b1;
        clear = 1'b1;
        tick;
        arvalid = 1'b0;
        clear = 1'b0;
        mwr = 0;
        mrd = 0;
        chk("clr_last_rd", last_rd_addr, 0);
        chk("clr_wr_count", wr_count, 0);
        chk("clr_rvalid", rvalid, 1);
        rready = 1'b1;
        tick;
        rready = 1'b0;
        mrd = sat(mrd + 1);
        chk("clr_rd_count", rd_count, mrd);

        // 20 back-to-back reads into a 4-bit counter
        hs = 0;
        n = 0;
        arvalid = 1'b1;
        rready = 1'b1;
        while (hs < 20 && n < 100) begin
            tick;
            n++;
            if (rvalid) begin
                hs++;
                mrd = sat(mrd + 1);
                if (hs == 20) arvalid = 1'b0;
            end
        end
        if (hs < 20) timeout("sat_reads");
        tick;
        rready = 1'b0;
        chk("sat_rd_count", rd_count, mrd);
        chk("sat_rd_max", rd_count, CMAX);

        send_ar(32'h7000);
        if (!rvalid) timeout("clr_r_valid");
        rready = 1'b1;
        clear = 1'b1;
        tick;
        rready = 1'b0;
        clear = 1'b0;
        mrd = 0;
        mwr = 0;
        chk("clrhs_rd_count", rd_count, mrd);
        chk("clrhs_last_rd", last_rd_addr, 0);
        chk("clrhs_arready", arready, 1);

        // reset while a write response is pending
        awaddr = 32'h8000;
        {awvalid, wvalid} = 2'b11;
        tick;
        {awvalid, wvalid} = 2'b00;
        bready = 1'b1;
        tick;
        bready = 1'b0;
        mwr = sat(mwr + 1);
        awaddr = 32'h8004;
        {awvalid, wvalid} = 2'b11;
        tick;
        {awvalid, wvalid} = 2'b00;
        chk("mr_bvalid_pre", bvalid, 1);
        chk("mr_wr_count_pre", wr_count, mwr);
        reset = 1'b1;
        #1;
        chk("mr_bvalid_drop", bvalid, 0);
        chk("mr_wr_count", wr_count, 0);
        chk("mr_readys", {awready, wready, arready}, 3'b000);
        mwr = 0;
        mrd = 0;
        tick;
        reset = 1'b0;
        tick;
        chk("mr_readys_back", {awready, wready, arready}, 3'b111);
        run_vec('{1'b1, 1'b0, 32'h9000, 1, XRESP, 32'h0});
        chk("mr_wr_after", wr_count, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
